// File: rtl/sigmoid_lut_pkg.sv
// Shared types and constants for the sigmoid LUT scheduler: FSM states,
// Q4.4 field layout and saturation bounds.
package sigmoid_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    INTERP = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int LUT_AW = 4;
  localparam int FRAC_W = 4;

  // Q4.4 split: address is the top LUT_AW bits, fraction the low FRAC_W bits
  localparam int Q_ADDR_LSB = FRAC_W;
  localparam int Q_W        = LUT_AW + FRAC_W;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sigmoid_lut_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  always_comb begin : search
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        j = int'(ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        if (!gnt_vld && req[j]) begin
          gnt_vld = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sigmoid_lut_sched.sv
// Round-robin scheduler sharing one sigmoid LUT among N_REQ requesters.
// Define SIGMOID_LUT_INTERP_EN to interpolate between adjacent entries.
module sigmoid_lut_sched
  import sigmoid_lut_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = 8,
  parameter int D_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*X_W-1:0]     req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [LUT_AW-1:0]        lut_address,
  input  logic [D_W-1:0]           lut_base,
  input  logic [D_W-1:0]           lut_next_data,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [D_W-1:0]           rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  state_t         state_q, state_n;
  logic [IW-1:0]  ptr_q, id_q, gnt_idx, ptr_inc;
  logic [N_REQ-1:0] gnt;
  logic           gnt_vld, arb_en;
  logic [X_W-1:0] x_q, x_sel;

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready   = gnt;
  assign x_sel       = req_x[gnt_idx*X_W +: X_W];
  assign ptr_inc     = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign lut_address = (state_q == IDLE) ? '0 : x_q[X_W-1 -: LUT_AW];
  assign busy        = (state_q != IDLE);

`ifdef SIGMOID_LUT_INTERP_EN
  localparam logic signed [D_W+2:0] Y_HI = (D_W+3)'(sat_hi(D_W));
  localparam logic signed [D_W+2:0] Y_LO = (D_W+3)'(sat_lo(D_W));

  logic [D_W-1:0]             base_q, next_q;
  logic [FRAC_W-1:0]          frac_q;
  logic signed [D_W:0]        diff;
  logic signed [D_W+FRAC_W+1:0] prod;
  logic signed [D_W+2:0]      y_ext;
  logic [D_W-1:0]             y_sat;

  // Dropping the low FRAC_W bits of prod is an arithmetic shift, i.e. floor.
  always_comb begin
    diff  = {next_q[D_W-1], next_q} - {base_q[D_W-1], base_q};
    prod  = diff * $signed({1'b0, frac_q});
    y_ext = {{3{base_q[D_W-1]}}, base_q}
          + {prod[D_W+FRAC_W+1], prod[D_W+FRAC_W+1:FRAC_W]};
    y_sat = y_ext[D_W-1:0];
    if (y_ext > Y_HI)      y_sat = Y_HI[D_W-1:0];
    else if (y_ext < Y_LO) y_sat = Y_LO[D_W-1:0];
  end
`else
  logic unused_ok;
  assign unused_ok = ^{lut_next_data, x_q[FRAC_W-1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:   if (gnt_vld) state_n = LOOKUP;
`ifdef SIGMOID_LUT_INTERP_EN
      LOOKUP: state_n = INTERP;
      INTERP: state_n = RESP;
`else
      LOOKUP: state_n = RESP;
`endif
      RESP:   if (rsp_valid && rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      id_q      <= '0;
      x_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef SIGMOID_LUT_INTERP_EN
      base_q    <= '0;
      next_q    <= '0;
      frac_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (gnt_vld) begin
          x_q   <= x_sel;
          id_q  <= gnt_idx;
          ptr_q <= ptr_inc;
        end
        LOOKUP: begin
`ifdef SIGMOID_LUT_INTERP_EN
          base_q <= lut_base;
          next_q <= lut_next_data;
          frac_q <= x_q[FRAC_W-1:0];
`else
          rsp_data  <= lut_base;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
`endif
        end
`ifdef SIGMOID_LUT_INTERP_EN
        INTERP: begin
          rsp_data  <= y_sat;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
`endif
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_sched.sv
// Bench for sigmoid_lut_sched: behavioural grant/latency/result model checked
// every cycle, plus directed cases with hand-computed results.
module tb_sigmoid_lut_sched;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int DW = 8;
`ifdef SIGMOID_LUT_INTERP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]    req_ready;
  logic [3:0]      lut_address;
  logic [DW-1:0]   lut_base, lut_next_data;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready;
  logic            busy;

  logic [7:0] lut [16];

  always #5 clk = ~clk;

  sigmoid_lut_sched #(.N_REQ(N), .X_W(XW), .D_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .lut_address(lut_address), .lut_base(lut_base),
    .lut_next_data(lut_next_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  // LUT model: 15 wraps to 0, entry 7 saturates to itself
  always_comb begin
    lut_base      = lut[lut_address];
    lut_next_data = (lut_address == 4'd7) ? lut[7] : lut[lut_address + 4'd1];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input logic [7:0] x);
    int a, f, b, n, p, y;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = int'($signed(lut[a]));
    n = (a == 7) ? b : int'($signed(lut[(a + 1) % 16]));
`ifdef SIGMOID_LUT_INTERP_EN
    p = (n - b) * f;
    y = b + (p >>> 4);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
`else
    p = n;
    y = b;
`endif
    return y;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit outst = 0, rst_seen = 0;
  int exp_id, exp_data, exp_addr, acc_cyc, ptr_m = 0;
  logic [N-1:0] last_take = '0;
  int done_id[$];
  int done_data[$];

  always @(negedge clk) begin : mon
    logic [N-1:0] take, exp_rdy;
    int g, gi, j;
    bit was;
    logic [7:0] x;
    if (rst) begin
      if (rst_seen) begin
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_lut_address", int'(lut_address), 0);
        chk("rst_req_ready", int'(req_ready), 0);
      end
      rst_seen  = 1;
      outst     = 0;
      ptr_m     = 0;
      last_take = '0;
    end else begin
      rst_seen = 0;
      was      = outst;
      take     = req_ready & req_valid;
      exp_rdy  = '0;
      g        = -1;
      if (!was) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      chk("busy", int'(busy), int'(was));
      if (was) begin
        chk("lut_address", int'(lut_address), exp_addr);
        if (cyc - acc_cyc <= LAT) chk("rsp_valid_early", int'(rsp_valid), 0);
        else begin
          chk("rsp_valid", int'(rsp_valid), 1);
          chk("rsp_id", int'(rsp_id), exp_id);
          chk("rsp_data", int'($signed(rsp_data)), exp_data);
          if (rsp_valid && rsp_ready) begin
            done_id.push_back(exp_id);
            done_data.push_back(exp_data);
            outst = 0;
          end
        end
        last_take = '0;
      end else begin
        chk("rsp_valid_idle", int'(rsp_valid), 0);
        last_take = take;
        if (take != '0) begin
          gi = 0;
          for (int k = N - 1; k >= 0; k--) if (take[k]) gi = k;
          x        = req_x[gi*XW +: XW];
          exp_id   = gi;
          exp_data = model(x);
          exp_addr = int'(x[7:4]);
          acc_cyc  = cyc;
          ptr_m    = (gi + 1) % N;
          outst    = 1;
        end
      end
    end
  end

  bit autodrop = 1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (autodrop) req_valid = req_valid & ~last_take;
  endtask

  task automatic do_one(input int id, input logic [7:0] x, input string nm, input int exp_d);
    int n0, b;
    n0 = done_data.size();
    req_x[id*XW +: XW] = x;
    req_valid[id] = 1'b1;
    b = 0;
    while (done_data.size() == n0 && b < 30) begin tick(); b++; end
    if (done_data.size() == n0) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_data"}, done_data[$], exp_d);
      chk({nm, "_id"}, done_id[$], id);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((busy || outst) && b < 50) begin tick(); b++; end
    chk("drain_idle", int'(busy), 0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  int tbl[16] = '{8, 11, 14, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0, 1, 4};

  initial begin : main
    int n0, b, cnt, d0, id0;
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) lut[i] = 8'(tbl[i]);
    repeat (3) tick();
    rst = 1'b0;
    tick();

`ifdef SIGMOID_LUT_INTERP_EN
    do_one(0, 8'h18, "x18", 12);
    do_one(1, 8'hF8, "xF8", 6);
    do_one(2, 8'h7F, "x7F", 15);
    do_one(3, 8'hEC, "xEC", 3);
`else
    do_one(0, 8'h18, "x18", 11);
    do_one(1, 8'hF8, "xF8", 4);
    do_one(2, 8'h7F, "x7F", 15);
    do_one(3, 8'hEC, "xEC", 1);
`endif
    do_one(3, 8'h88, "x88", 0);

    // round robin with requesters 0 and 2 held valid
    autodrop = 0;
    req_x[0*XW +: XW] = 8'h20;
    req_x[2*XW +: XW] = 8'h00;
    req_valid = 4'b0101;
    n0 = done_data.size();
    b = 0;
    while (done_data.size() < n0 + 4 && b < 40) begin tick(); b++; end
    if (done_data.size() < n0 + 4) chk("rr_timeout", 0, 1);
    else for (int k = 0; k < 4; k++) begin
      chk("rr_id", done_id[n0 + k], (k % 2 == 0) ? 0 : 2);
      chk("rr_data", done_data[n0 + k], (k % 2 == 0) ? 14 : 8);
    end
    req_x[3*XW +: XW] = 8'h40;
    req_valid[3] = 1'b1;
    cnt = 0;
    b = 0;
    do begin tick(); cnt += $countones(last_take); b++; end
    while (!last_take[3] && b < 40);
    chk("rr_req3_granted", int'(last_take[3]), 1);
    chk("rr_req3_within2", int'(cnt <= 2), 1);
    req_valid = '0;
    autodrop = 1;
    drain();

    // backpressure
    rsp_ready = 1'b0;
    req_x[1*XW +: XW] = 8'h30;
    req_x[2*XW +: XW] = 8'h50;
    req_valid = 4'b0110;
    b = 0;
    while (!rsp_valid && b < 10) begin tick(); b++; end
    chk("bp_rsp_valid_rise", int'(rsp_valid), 1);
    d0 = int'(rsp_data);
    id0 = int'(rsp_id);
    repeat (5) begin
      tick();
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_data", int'(rsp_data), d0);
      chk("bp_hold_id", int'(rsp_id), id0);
      chk("bp_req_ready_blocked", int'(req_ready), 0);
    end
    n0 = done_data.size();
    rsp_ready = 1'b1;
    tick();
    chk("bp_complete", done_data.size(), n0 + 1);
    chk("bp_valid_dropped", int'(rsp_valid), 0);
    b = 0;
    while (done_data.size() < n0 + 2 && b < 20) begin tick(); b++; end
    chk("bp_second_served", done_data.size(), n0 + 2);
    drain();

    // reset while the lookup is in flight
    req_x[2*XW +: XW] = 8'h18;
    req_valid[2] = 1'b1;
    b = 0;
    do begin tick(); b++; end while (!last_take[2] && b < 20);
    chk("rst_req_taken", int'(last_take[2]), 1);
    tick();
    rst = 1'b1;
    req_valid = '0;
    n0 = done_data.size();
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("rst_no_rsp", done_data.size(), n0);
    req_x[0*XW +: XW] = 8'h20;
    req_x[3*XW +: XW] = 8'h00;
    req_valid = 4'b1001;
    b = 0;
    do begin tick(); b++; end while (last_take == '0 && b < 10);
    chk("rst_first_grant", int'(last_take), 1);
    b = 0;
    while (req_valid != '0 && b < 30) begin tick(); b++; end
    drain();

    // randomized traffic over a random LUT
    for (int i = 0; i < 16; i++) lut[i] = 8'($urandom);
    n0 = done_data.size();
    repeat (2500) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_x[i*XW +: XW] = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    drain();
    chk("rand_progress", int'(done_data.size() > n0 + 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/sigmoid_lut_sched.md
Name: sigmoid_lut_sched

Overview:
- Shares one 16-entry sigmoid LUT (combinational: 4-bit address in; signed 8-bit base and next_data out) between N neuron requesters.
- Round-robin arbitration selects one requester at a time.
- The block sequences the LUT lookup and linearly interpolates between base and next_data using the low nibble of the input.
- Sits between the layer's neuron accumulators and the LUT instance of the sigmoid activation function.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- X_W, 8, requester input width; signed Q4.4, address = x[7:4], frac = x[3:0]
- D_W, 8, LUT data and result width (signed)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_x  in  N_REQ*X_W  packed inputs; requester i occupies bits [i*X_W +: X_W]
- req_ready  out  N_REQ  one-hot accept; at most one bit high
- lut_address  out  4  address to the LUT
- lut_base  in  D_W  LUT base entry, valid in the same cycle as lut_address
- lut_next_data  in  D_W  LUT following entry; the LUT itself handles the 15->0 wrap and the 7-saturate
- rsp_valid  out  1  result valid
- rsp_id  out  $clog2(N_REQ)  index of the requester the result belongs to
- rsp_data  out  D_W  sigmoid result
- rsp_ready  in  1  consumer accepts the result
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, lut_address=0, busy=0. A reset in any state aborts the operation in flight with no response. A requester whose request was accepted gets no result.
- FSM states: IDLE, LOOKUP, INTERP, RESP.
- IDLE:
  - The grant is the first requester with req_valid=1, searching from the rr pointer upward with wrap.
  - req_ready is driven combinationally to that one bit.
  - On a transfer: x_q<=req_x[g], id_q<=g, pointer<=g+1 (mod N_REQ), go to LOOKUP.
  - No valid request: stay in IDLE, req_ready=0.
- LOOKUP:
  - lut_address=x_q[7:4]; base_q<=lut_base, next_q<=lut_next_data, frac_q<=x_q[3:0].
  - Go to INTERP.
  - lut_address holds x_q[7:4] in all non-IDLE states.
- INTERP:
  - diff = next_q - base_q, signed 9-bit.
  - prod = diff * {1'b0, frac_q}, signed 14-bit.
  - y = base_q + (prod >>> 4), arithmetic shift, rounding toward negative infinity.
  - Saturate y to [-128, 127]; rsp_data<=y, rsp_id<=id_q, rsp_valid<=1.
  - Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_valid & rsp_ready.
  - On that cycle: rsp_valid<=0, go to IDLE.
  - No new request is accepted while in RESP.
- Latency: accept at edge 0; rsp_valid is high after edge 2. Best-case throughput is 1 result per 4 cycles, when rsp_ready is tied high.
- A requester must hold req_valid and req_x until it sees req_ready. Requests that are not granted are unaffected.
- Simultaneous requests: exactly one is granted. Starvation-free: every valid requester is granted within N_REQ grants.
- Address boundaries:
  - x=0x7F uses address 7 (next = base, saturating).
  - x=0xF8 uses address 15 (next = lut[0]).
  - No special handling is needed in this block.

Optional Feature:
- Macro: SIGMOID_LUT_INTERP_EN.
- Defined: behaviour as above.
- Undefined:
  - INTERP state removed.
  - In LOOKUP, rsp_data<=lut_base, rsp_id<=id_q, rsp_valid<=1, go to RESP.
  - Nearest-lower-entry result; latency reduced by one cycle.
  - frac is ignored, no multiplier is synthesized, and frac_q and next_q are removed.

Decomposition:
- Package sigmoid_lut_pkg contains:
  - State enum (IDLE, LOOKUP, INTERP, RESP).
  - LUT_AW=4 and FRAC_W=4 constants.
  - Q4.4 split helpers (address/fraction field widths).
  - Saturation bounds.
- One sub-module, rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and binary index.
  - Combinational; the pointer register stays in sigmoid_lut_sched.

Test Plan:
- LUT model {8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4}; requester 0 sends x=0x18 -> req_ready[0] for one cycle, rsp_valid 3 cycles later, rsp_data=12, rsp_id=0.
- Wrap and saturate: x=0xF8 -> 6; x=0x7F -> 15; x=0xEC -> 3; x=0x88 -> 0.
- Round-robin, N_REQ=4: requesters 0 and 2 held valid (x=0x20 and 0x00), rsp_ready=1 -> grant order 0,2,0,2 with rsp_data 14,8,14,8; requester 3 raised later is granted within 2 grants.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable; req_ready stays 0 for pending requesters; completes on the cycle rsp_ready rises.
- Reset asserted during INTERP -> next cycle all outputs at reset values; pointer=0; no response for the aborted request; the following request is served from requester 0 first.
- SIGMOID_LUT_INTERP_EN undefined: x=0x18 -> rsp_data=11 with rsp_valid 2 cycles after accept.
